// File: rtl/fetch_unit_if.sv
// Bundles the instruction-memory, decode and redirect signals of the fetch unit.
// fetch_err exists only when FETCH_MISALIGN_CHK_EN is defined.
interface fetch_unit_if #(
  parameter int unsigned XLEN = 32
) ();
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [XLEN-1:0] imem_rsp_data;
  logic            inst_valid;
  logic            inst_ready;
  logic [XLEN-1:0] inst_data;
  logic [XLEN-1:0] inst_pc;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
`ifdef FETCH_MISALIGN_CHK_EN
  logic            fetch_err;
`endif

  // Fetch-unit side.
  modport master (
`ifdef FETCH_MISALIGN_CHK_EN
    output fetch_err,
`endif
    output imem_req_valid,
    output imem_req_addr,
    input  imem_req_ready,
    input  imem_rsp_valid,
    input  imem_rsp_data,
    output inst_valid,
    output inst_data,
    output inst_pc,
    input  inst_ready,
    input  redirect_valid,
    input  redirect_pc
  );

  // Memory / decode / execute side.
  modport slave (
`ifdef FETCH_MISALIGN_CHK_EN
    input  fetch_err,
`endif
    input  imem_req_valid,
    input  imem_req_addr,
    output imem_req_ready,
    output imem_rsp_valid,
    output imem_rsp_data,
    input  inst_valid,
    input  inst_data,
    input  inst_pc,
    output inst_ready,
    output redirect_valid,
    output redirect_pc
  );
endinterface

// File: rtl/fetch_unit.sv
// Decoupled instruction fetch: credit-limited PC generator, in-order response path and
// {pc, instruction} FIFO. Define FETCH_MISALIGN_CHK_EN to halt on misaligned redirects.
module fetch_unit #(
  parameter int unsigned     XLEN            = 32,
  parameter logic [XLEN-1:0] RESET_PC        = '0,
  parameter int unsigned     FIFO_DEPTH      = 4,
  parameter int unsigned     MAX_OUTSTANDING = 4
) (
  input logic          clk,
  input logic          reset,
  fetch_unit_if.master bus
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned OutW = $clog2(MAX_OUTSTANDING + 1);

  typedef enum logic [1:0] {StBoot, StRun, StHalt} state_e;

  state_e          state_q;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] resp_pc_q, resp_pc_d;
  logic [OutW-1:0] outstanding_q, outstanding_d;
  logic [OutW-1:0] discard_q, discard_d;
  logic [CntW-1:0] count_q, count_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [XLEN-1:0] fifo_pc_q   [FIFO_DEPTH];
  logic [XLEN-1:0] fifo_data_q [FIFO_DEPTH];

  logic            run;
  logic            redirect;
  logic [XLEN-1:0] redirect_target;
  logic [31:0]     inflight;
  logic            req_valid;
  logic            req_fire;
  logic            rsp_keep;
  logic            push;
  logic            pop;
  logic            fifo_valid;

  assign run      = (state_q == StRun);
  assign redirect = run && bus.redirect_valid;

`ifdef FETCH_MISALIGN_CHK_EN
  logic err_q;
  logic misalign;
  assign redirect_target = bus.redirect_pc;
  assign misalign        = redirect && (bus.redirect_pc[1:0] != 2'b00);
  assign bus.fetch_err   = err_q;
`else
  assign redirect_target = {bus.redirect_pc[XLEN-1:2], 2'b00};
`endif

  // Credit rule: every accepted request already owns a FIFO slot for its response.
  assign inflight  = 32'(count_q) + 32'(outstanding_q);
  assign req_valid = run && !bus.redirect_valid && (inflight < FIFO_DEPTH) &&
                     (32'(outstanding_q) < MAX_OUTSTANDING);
  assign req_fire  = req_valid && bus.imem_req_ready;

  assign rsp_keep   = bus.imem_rsp_valid && (discard_q == '0);
  assign push       = rsp_keep && !redirect;
  assign fifo_valid = (count_q != '0);
  assign pop        = fifo_valid && bus.inst_ready && !redirect;

  assign bus.imem_req_valid = req_valid;
  assign bus.imem_req_addr  = pc_q;
  assign bus.inst_valid     = fifo_valid;
  assign bus.inst_data      = fifo_valid ? fifo_data_q[rd_ptr_q] : '0;
  assign bus.inst_pc        = fifo_valid ? fifo_pc_q[rd_ptr_q] : '0;

  always_comb begin
    pc_d          = pc_q;
    resp_pc_d     = resp_pc_q;
    outstanding_d = outstanding_q;
    discard_d     = discard_q;
    count_d       = count_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;

    if (req_fire && !bus.imem_rsp_valid) begin
      outstanding_d = outstanding_q + OutW'(1);
    end else if (!req_fire && bus.imem_rsp_valid) begin
      outstanding_d = outstanding_q - OutW'(1);
    end

    if (redirect) begin
      // Everything still in flight, including a response landing now, is stale.
      pc_d      = redirect_target;
      resp_pc_d = redirect_target;
      discard_d = outstanding_q - OutW'(bus.imem_rsp_valid);
      count_d   = '0;
      rd_ptr_d  = '0;
      wr_ptr_d  = '0;
    end else begin
      if (req_fire) begin
        pc_d = pc_q + XLEN'(4);
      end
      if (bus.imem_rsp_valid && (discard_q != '0)) begin
        discard_d = discard_q - OutW'(1);
      end
      if (push) begin
        resp_pc_d = resp_pc_q + XLEN'(4);
        wr_ptr_d  = wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PtrW'(1);
      end
      if (push && !pop) begin
        count_d = count_q + CntW'(1);
      end else if (!push && pop) begin
        count_d = count_q - CntW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StBoot;
`ifdef FETCH_MISALIGN_CHK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        StBoot: state_q <= StRun;
        StRun: begin
`ifdef FETCH_MISALIGN_CHK_EN
          if (misalign) begin
            state_q <= StHalt;
            err_q   <= 1'b1;
          end
`endif
        end
        StHalt:  state_q <= StHalt;
        default: state_q <= StBoot;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q          <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      outstanding_q <= '0;
      discard_q     <= '0;
      count_q       <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
    end else begin
      pc_q          <= pc_d;
      resp_pc_q     <= resp_pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      count_q       <= count_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
    end
  end

  // Storage needs no reset: empty entries are masked on the outputs.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_pc_q[wr_ptr_q]   <= resp_pc_q;
      fifo_data_q[wr_ptr_q] <= bus.imem_rsp_data;
    end
  end

endmodule
